// File: rtl/core_fetch.sv
// Instruction fetch stage: issues single outstanding word reads, buffers returned
// words with their PCs in a small prefetch FIFO and presents one per cycle to control.
module core_fetch #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [29:0] RESET_PC = 30'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic [29:0] branch_target,
    input  logic        fetch_ready,
    input  logic [31:0] fetch_data,
    output logic        fetch_start,
    output logic [29:0] fetch_addr,
    output logic [31:0] insn,
    output logic [29:0] insn_pc,
    output logic        insn_valid,
    output logic        flushing
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [31:0] NOP = 32'hE1A00000;

    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_e;

    state_e        state_q;
    logic          fetch_start_q;
    logic [29:0]   fetch_addr_q;
    logic [29:0]   ptr_q;
    logic          flush_q;
    logic [31:0]   insn_q;
    logic [29:0]   insn_pc_q;
    logic          insn_valid_q;
    logic [31:0]   data_q [DEPTH];
    logic [29:0]   pc_q   [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done, push, pop, issue;

    // A read cannot complete in the cycle it is started, so a stale ready that
    // lines up with a fresh fetch_start (e.g. just after reset) is ignored.
    always_comb begin
        done  = (state_q != IDLE) && fetch_ready && !fetch_start_q;
        push  = (state_q == BUSY) && done && !branch;
        pop   = !stall && !branch && (cnt_q != '0);
        issue = (state_q == IDLE) && !branch && (cnt_q < CW'(DEPTH));
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            fetch_start_q <= 1'b0;
            fetch_addr_q  <= RESET_PC;
            ptr_q         <= RESET_PC;
            flush_q       <= 1'b0;
            insn_q        <= NOP;
            insn_pc_q     <= RESET_PC;
            insn_valid_q  <= 1'b0;
            rd_q          <= '0;
            wr_q          <= '0;
            cnt_q         <= '0;
        end else begin
            fetch_start_q <= 1'b0;
            if (branch) begin
                ptr_q        <= branch_target;
                rd_q         <= '0;
                wr_q         <= '0;
                cnt_q        <= '0;
                insn_q       <= NOP;
                insn_valid_q <= 1'b0;
                if ((state_q != IDLE) && !done) begin
                    state_q <= DROP;
                    flush_q <= 1'b1;
                end else begin
                    state_q <= IDLE;
                    flush_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    IDLE: if (issue) begin
                        state_q       <= BUSY;
                        fetch_start_q <= 1'b1;
                        fetch_addr_q  <= ptr_q;
                        ptr_q         <= ptr_q + 30'd1;
                    end
                    BUSY: if (done) state_q <= IDLE;
                    DROP: if (done) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
                if (push) begin
                    data_q[wr_q] <= fetch_data;
                    pc_q[wr_q]   <= fetch_addr_q;
                    wr_q         <= wr_q + AW'(1);
                end
                if (pop) begin
                    insn_q       <= data_q[rd_q];
                    insn_pc_q    <= pc_q[rd_q];
                    insn_valid_q <= 1'b1;
                    rd_q         <= rd_q + AW'(1);
                end else if (!stall) begin
                    insn_q       <= NOP;
                    insn_valid_q <= 1'b0;
                end
                cnt_q <= cnt_d;
            end
        end
    end

    assign fetch_start = fetch_start_q;
    assign fetch_addr  = fetch_addr_q;
    assign insn        = insn_q;
    assign insn_pc     = insn_pc_q;
    assign insn_valid  = insn_valid_q;
    assign flushing    = flush_q;
endmodule
